// File: rtl/uart_cmd_comm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_cmd_comm                                                    |
// | Purpose : Host-side comm stage. UART receiver + 3-byte command assembler   |
// |           (cmd/cmd_rdy) and UART transmitter for single response bytes.    |
// | Ports   : clk, rst_n     - clock, asynchronous active-low reset            |
// |           RX / TX        - serial in / out, idle high                      |
// |           cmd[23:0]      - assembled command {byte0,byte1,byte2}           |
// |           cmd_rdy        - command valid level                             |
// |           clr_cmd_rdy    - consumer acknowledge, clears cmd_rdy            |
// |           resp_data[7:0] - response byte to transmit                       |
// |           send_resp      - 1-cycle transmit request                        |
// |           resp_sent      - 1-cycle pulse after the response stop bit       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module uart_cmd_comm #(
  parameter int BAUD_DIV     = 2604,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp_data,
  input  logic        send_resp,
  output logic        resp_sent
);

  localparam int CW       = $clog2(BAUD_DIV) + 1;
  localparam int TO_LIMIT = TIMEOUT_BITS * BAUD_DIV;
  localparam int TW       = $clog2(TO_LIMIT) + 1;

  localparam logic [CW-1:0] c_BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] c_HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam logic [TW-1:0] c_TO_LAST   = TW'(TO_LIMIT - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_START = 2'd1;
  localparam logic [1:0] c_DATA  = 2'd2;
  localparam logic [1:0] c_STOP  = 2'd3;

  // ---------------- receiver ----------------
  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic [1:0]    rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_byte_valid, rx_frame_err;

  always_comb begin
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    rx_byte_valid = 1'b0;
    rx_frame_err  = 1'b0;
    case (rx_state_q)
      c_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = c_START;
          rx_cnt_d   = '0;
        end
      end
      c_START: begin
        // Re-check the line at mid start bit; a high level means a glitch.
        if (rx_cnt_q == c_HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? c_IDLE : c_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      c_DATA: begin
        if (rx_cnt_q == c_BAUD_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_d = c_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: begin
        if (rx_cnt_q == c_BAUD_LAST) begin
          rx_cnt_d      = '0;
          rx_state_d    = c_IDLE;
          rx_byte_valid = rx_sync_q;
          rx_frame_err  = !rx_sync_q;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
    endcase
  end

  // ---------------- command assembler ----------------
  logic [23:0]   cmd_q, cmd_d;
  logic          cmd_rdy_q, cmd_rdy_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [TW-1:0] to_q, to_d;

  always_comb begin
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q;
    bcnt_d    = bcnt_q;
    to_d      = to_q;
    if (clr_cmd_rdy) cmd_rdy_d = 1'b0;
    if (rx_frame_err) begin
      bcnt_d = 2'd0;
    end else if (rx_byte_valid) begin
      case (bcnt_q)
        2'd1: begin
          cmd_d[15:8] = rx_shift_q;
          bcnt_d      = 2'd2;
        end
        2'd2: begin
          // Completion overrides a simultaneous clear.
          cmd_d[7:0] = rx_shift_q;
          cmd_rdy_d  = 1'b1;
          bcnt_d     = 2'd0;
        end
        default: begin
          cmd_d[23:16] = rx_shift_q;
          cmd_rdy_d    = 1'b0;
          bcnt_d       = 2'd1;
        end
      endcase
    end
    // Inter-byte timeout: only counts while a command is partially received.
    if (rx_state_q != c_IDLE || bcnt_q == 2'd0) begin
      to_d = '0;
    end else if (to_q == c_TO_LAST) begin
      to_d   = '0;
      bcnt_d = 2'd0;
    end else begin
      to_d = to_q + 1'b1;
    end
  end

  // ---------------- transmitter ----------------
  logic [1:0]    tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_q, tx_d;
  logic          resp_sent_q, resp_sent_d;

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_d        = tx_q;
    resp_sent_d = 1'b0;
    case (tx_state_q)
      c_IDLE: begin
        tx_d = 1'b1;
        if (send_resp) begin
          tx_state_d = c_START;
          tx_cnt_d   = '0;
          tx_shift_d = resp_data;
          tx_d       = 1'b0;
        end
      end
      c_START: begin
        if (tx_cnt_q == c_BAUD_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = c_DATA;
          tx_d       = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      c_DATA: begin
        if (tx_cnt_q == c_BAUD_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = c_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_shift_d = {1'b1, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: begin
        if (tx_cnt_q == c_BAUD_LAST) begin
          tx_cnt_d    = '0;
          tx_state_d  = c_IDLE;
          resp_sent_d = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= c_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      cmd_q       <= '0;
      cmd_rdy_q   <= 1'b0;
      bcnt_q      <= 2'd0;
      to_q        <= '0;
      tx_state_q  <= c_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_q        <= 1'b1;
      resp_sent_q <= 1'b0;
    end else begin
      rx_meta_q   <= RX;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
      bcnt_q      <= bcnt_d;
      to_q        <= to_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_q        <= tx_d;
      resp_sent_q <= resp_sent_d;
    end
  end

  assign TX        = tx_q;
  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign resp_sent = resp_sent_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_comm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_uart_cmd_comm                                                 |
// | Purpose : Self-checking bench for uart_cmd_comm (BAUD_DIV=16,             |
// |           TIMEOUT_BITS=4). Frame-level reference model for the command     |
// |           path, timeline model for the transmitter.                        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_uart_cmd_comm;
  localparam int BAUD = 16;
  localparam int TOB  = 4;
  localparam int FRAME = 10 * BAUD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp_data = 8'h00;
  logic        send_resp = 1'b0;
  logic        resp_sent;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_cmd_comm #(.BAUD_DIV(BAUD), .TIMEOUT_BITS(TOB)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp_data(resp_data), .send_resp(send_resp),
    .resp_sent(resp_sent)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [23:0] m_cmd = 24'h0;
  logic        m_rdy = 1'b0;
  logic [7:0]  m_pend[$];
  bit          skip_rx = 1'b0;     // command outputs are in flux around a stop-bit sample
  int          cyc = 0;
  bit          tx_act = 1'b0;
  int          tx_req = 0;         // clk index in which the accepted request was presented
  logic [7:0]  tx_byte = 8'h00;
  int          rs_q[$];
  int          acc_q[$];

  function automatic void model_byte(input logic [7:0] b, input bit stop_ok,
                                     input bit timed_out, input bit clr_seen);
    int idx;
    if (timed_out) m_pend.delete();
    if (!stop_ok) begin
      m_pend.delete();
      return;
    end
    if (m_pend.size() == 0) m_rdy = 1'b0;
    idx = 23 - 8 * m_pend.size();
    m_cmd[idx -: 8] = b;
    m_pend.push_back(b);
    if (m_pend.size() == 3) begin
      m_rdy = 1'b1;
      m_pend.delete();
    end
    if (clr_seen) m_rdy = 1'b0;
  endfunction

  // Expected TX level k clks after the accepted request: start, 8 data LSB first, stop.
  function automatic logic exp_tx(input int c);
    int k;
    k = c - tx_req;
    if (!tx_act || k < 1 || k > FRAME) return 1'b1;
    if (k <= BAUD) return 1'b0;
    if (k > 9 * BAUD) return 1'b1;
    return tx_byte[(k - 1) / BAUD - 1];
  endfunction

  function automatic logic exp_rs(input int c);
    return tx_act && (c - tx_req == FRAME + 1);
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (!skip_rx) begin
        check("cmd", {8'h0, cmd}, {8'h0, m_cmd});
        check("cmd_rdy", {31'h0, cmd_rdy}, {31'h0, m_rdy});
      end
      check("TX", {31'h0, TX}, {31'h0, exp_tx(cyc)});
      check("resp_sent", {31'h0, resp_sent}, {31'h0, exp_rs(cyc)});
      if (resp_sent === 1'b1) rs_q.push_back(cyc);
      if (clr_cmd_rdy && !skip_rx) m_rdy = 1'b0;
      if (send_resp && (!tx_act || cyc - tx_req >= FRAME + 1)) begin
        tx_act  = 1'b1;
        tx_req  = cyc;
        tx_byte = resp_data;
        acc_q.push_back(cyc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame starting right after a clock edge. Around the stop-bit
  // sample the bench observes cmd/cmd_rdy itself, then updates the model.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int idle_before,
                            input bit clr_window, output int rdy_hi, output int j_fall,
                            output int j_hi);
    logic [9:0] fr;
    fr = {stop_ok, b, 1'b0};
    rdy_hi = 0;
    j_fall = -1;
    j_hi   = -1;
    RX = 1'b1;
    if (idle_before > 0) tick(idle_before);
    for (int i = 0; i < 9; i++) begin
      RX = fr[i];
      tick(BAUD);
    end
    RX = fr[9];
    tick(BAUD / 2 - 2);
    skip_rx = 1'b1;
    if (clr_window) clr_cmd_rdy = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (cmd_rdy === 1'b1) rdy_hi++;
      if (j_fall < 0 && cmd_rdy === 1'b0) j_fall = j;
      if (j_hi < 0 && cmd[23:16] === b) j_hi = j;
      @(posedge clk);
      #1;
    end
    model_byte(b, stop_ok, idle_before >= TOB * BAUD, clr_window);
    skip_rx = 1'b0;
    clr_cmd_rdy = 1'b0;
    RX = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input int idle_before);
    int a, f, h;
    send_frame(b, 1'b1, idle_before, 1'b0, a, f, h);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int a, f, h;
    logic [9:0] bits;
    bits = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_TX", {31'h0, TX}, 32'h1);
    check("rst_cmd", {8'h0, cmd}, 32'h0);
    check("rst_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
    check("rst_resp_sent", {31'h0, resp_sent}, 32'h0);
    rst_n = 1'b1;
    tick(3);

    // Full duplex: a command arrives while two responses go out.
    fork
      begin
        send(8'h12, 2);
        send(8'h34, 0);
        send(8'h56, 0);
      end
      begin
        resp_data = 8'hA5;
        send_resp = 1'b1;
        for (int k = 1; k <= FRAME + 1; k++) begin
          tick(1);
          if (k == 1 || k == 51) send_resp = 1'b0;
          if (k == 50) begin
            resp_data = 8'hFF;
            send_resp = 1'b1;
          end
          if (k >= 8 && k <= 152 && (k - 8) % BAUD == 0) bits[(k - 8) / BAUD] = TX;
        end
        resp_data = 8'h3C;
        send_resp = 1'b1;
        tick(1);
        send_resp = 1'b0;
        tick(FRAME + 10);
      end
    join
    check("tx_bits_A5", {22'h0, bits}, {22'h0, 10'b1101001010});
    check("resp_sent_count", rs_q.size(), 2);
    check("accepted_count", acc_q.size(), 2);
    if (rs_q.size() == 2 && acc_q.size() == 2) begin
      check("resp_sent_at_161", rs_q[0] - acc_q[0], 161);
      check("b2b_accept_at_161", acc_q[1] - acc_q[0], 161);
      check("b2b_resp_sent", rs_q[1] - rs_q[0], 161);
    end
    check("cmd_123456", {8'h0, cmd}, 32'h123456);
    check("rdy_123456", {31'h0, cmd_rdy}, 32'h1);

    // New command while the previous one is still flagged ready.
    send_frame(8'hAB, 1'b1, 2, 1'b0, a, f, h);
    check("ab_hi_seen", {31'h0, (h >= 0)}, 32'h1);
    check("ab_same_edge", f, h);
    send(8'hCD, 0);
    send(8'hEF, 0);
    check("cmd_ABCDEF", {8'h0, cmd}, 32'hABCDEF);
    check("rdy_ABCDEF", {31'h0, cmd_rdy}, 32'h1);
    clr_cmd_rdy = 1'b1;
    tick(1);
    clr_cmd_rdy = 1'b0;
    check("clr_next_clk", {31'h0, cmd_rdy}, 32'h0);
    tick(20);

    // Clear held across third-byte completion: ready must still pulse once.
    send(8'h21, 2);
    send(8'h43, 0);
    send_frame(8'h65, 1'b1, 0, 1'b1, a, f, h);
    check("set_wins_pulse", a, 1);
    check("cmd_214365", {8'h0, cmd}, 32'h214365);
    tick(5);

    // Inter-byte timeout resynchronises the byte count.
    send(8'h11, 2);
    send(8'h22, TOB * BAUD + 1);
    send_frame(8'h33, 1'b1, 0, 1'b0, a, f, h);
    check("timeout_no_early_rdy", a, 0);
    send_frame(8'h44, 1'b1, 0, 1'b0, a, f, h);
    check("timeout_rdy_after_44", {31'h0, (a > 0)}, 32'h1);
    check("cmd_223344", {8'h0, cmd}, 32'h223344);

    // Framing error drops the byte; a short low glitch is not a start bit.
    send(8'h77, 2);
    send_frame(8'h5A, 1'b0, 2, 1'b0, a, f, h);
    send(8'h01, 20);
    tick(10);
    RX = 1'b0;
    tick(4);
    RX = 1'b1;
    tick(20);
    send(8'h02, 2);
    send(8'h03, 0);
    check("cmd_010203", {8'h0, cmd}, 32'h010203);
    check("rdy_010203", {31'h0, cmd_rdy}, 32'h1);
    tick(5);

    // Reset in the middle of an RX frame and a TX frame.
    resp_data = 8'h5A;
    send_resp = 1'b1;
    tick(1);
    send_resp = 1'b0;
    RX = 1'b0;
    tick(BAUD);
    RX = 1'b1;
    tick(6);
    #2;
    rst_n = 1'b0;
    m_cmd = 24'h0;
    m_rdy = 1'b0;
    m_pend.delete();
    tx_act = 1'b0;
    #1;
    check("midrst_TX", {31'h0, TX}, 32'h1);
    check("midrst_cmd", {8'h0, cmd}, 32'h0);
    check("midrst_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
    tick(3);
    rst_n = 1'b1;
    tick(5);
    send(8'h5E, 2);
    send(8'h6F, 0);
    send(8'h70, 0);
    check("cmd_5E6F70", {8'h0, cmd}, 32'h5E6F70);
    check("rdy_5E6F70", {31'h0, cmd_rdy}, 32'h1);
    resp_data = 8'h81;
    send_resp = 1'b1;
    tick(1);
    send_resp = 1'b0;
    tick(FRAME + 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
